irq_ctrl: RTL
=============

# irq_ctrl

Parametrised multi-channel interrupt controller between external interrupt sources and the `mips` core's single interrupt input. It synchronises N asynchronous request lines and latches edge- or level-mode events per channel. It masks, priority-encodes and presents one request with a channel ID to the core over a request/acknowledge handshake, and tracks in-service state until the handler signals end-of-interrupt.

## Interface
- `N_CH`, 4: number of channels, 1..32; channel 0 is highest priority.
- `ID_W`, 2: width of `irq_id`, ≥ clog2(N_CH), minimum 1.
- `SYNC_STAGES`, 2: synchroniser flops per input, ≥ 2.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `irq_in` in N_CH: asynchronous raw interrupt lines.
- `mask_we` in 1: load `mask` from `mask_wdata`.
- `mask_wdata` in N_CH: 1 = channel enabled.
- `mode_we` in 1: load `mode` from `mode_wdata`.
- `mode_wdata` in N_CH: 1 = rising-edge mode, 0 = level mode.
- `irq_req` out 1: request to core.
- `irq_id` out ID_W: channel being requested or last acknowledged.
- `irq_ack` in 1: one-cycle pulse, core accepts the request.
- `eoi` in 1: one-cycle pulse, handler finished (issued on ERET).
- `pending` out N_CH: pending vector, for debug readout.
- `in_service` out N_CH: in-service vector, for debug readout.

## Operation
- Reset values: `irq_req`=0, `irq_id`=0, `pending`=0, `in_service`=0, synchronisers=0, `mask`=0 (all masked), `mode`=all ones (edge). FSM resets to IDLE.
- Synchroniser: `SYNC_STAGES` flops per channel, plus one history flop for edge detect.
- Edge mode: a synced 0→1 transition sets `pending[i]`, which holds until acknowledged.
- Level mode: `pending[i]` = synced level every cycle and is never latched.
- Eligible = `pending & mask & ~in_service`. Winner = lowest eligible index.
- FSM:
  - IDLE: if eligible≠0 and `in_service`=0, load `irq_id`=winner, `irq_req`=1, go to REQ.
  - REQ: `irq_id` is held stable; no retargeting to a higher-priority arrival.
    - On `irq_ack`: `irq_req`=0, set `in_service[irq_id]`, clear `pending[irq_id]` if edge mode, go to SERVICE.
    - If `mask[irq_id]` becomes 0, or a level-mode source deasserts before ack: withdraw, `irq_req`=0, go to IDLE.
  - SERVICE: no new request. On `eoi`, clear the lowest-index set bit of `in_service`, then go to IDLE.
- Simultaneous events:
  - New edge on the same channel as an ack-clear in the same cycle: set wins, `pending` stays 1.
  - `mask_we`/`mode_we` take effect for eligibility from the next cycle.
  - `irq_ack` outside REQ is ignored. `eoi` with `in_service`=0 is ignored.
  - `irq_ack` and `eoi` in the same cycle: ack is processed and eoi is ignored.
- Mode change edge→level on a pending channel: the pending bit follows level from the next cycle.
- Reset mid-operation: all state returns asynchronously to reset values, and `irq_req` drops immediately.

## Timing
- Edge-mode latency, counted from the first rising `clk` sampling `irq_in[i]`=1:
  - `pending[i]`=1 after SYNC_STAGES+1 edges.
  - `irq_req`=1 one edge later, giving SYNC_STAGES+2 in total (4 by default).
- Level mode has the same latency.
- `irq_ack` high at edge k: `irq_req`=0 and `in_service` updated after edge k.
- `eoi` at edge k: IDLE after edge k; the next `irq_req` can rise at edge k+1.
- Minimum pulse width on `irq_in` to guarantee capture: one `clk` period plus setup/hold.

## Configuration
- `IRQ_NEST_EN` defined: nested interrupts are supported.
  - In SERVICE, if winner index < lowest set `in_service` index, the controller raises a new request (REQ) with that ID.
  - Ack adds an `in_service` bit.
  - `eoi` clears the lowest-index set bit and returns to SERVICE if `in_service`≠0, else IDLE.
  - Withdraw from a nested REQ returns to SERVICE.
- `IRQ_NEST_EN` undefined: behaviour exactly as in Operation. At most one `in_service` bit is ever set.

## Test plan
- Reset, `mask`=4'b0001, 20 ns pulse on `irq_in[0]` → `irq_req`=1 and `irq_id`=0 four cycles after the first sampling edge. `irq_ack` → `irq_req`=0, `in_service`=4'b0001, `pending`=0. `eoi` → `in_service`=0.
- `mask`=4'b1111, pulses on `irq_in[3]` and `irq_in[1]` in the same cycle → `irq_id`=1 first. After ack+eoi → `irq_id`=3 is requested. After ack+eoi → `pending`=0.
- `mask`=4'b0000, pulse `irq_in[2]` → `pending`=4'b0100 and no `irq_req`. Write `mask`=4'b0100 → `irq_req`=1 with `irq_id`=2 two cycles after the write.
- `mode`=4'b1110 (ch0 level):
  - Hold `irq_in[0]` high → requested. Ack → no re-request while in service. eoi with `irq_in[0]` still high → re-requested.
  - Drop `irq_in[0]` during REQ → withdraw, `irq_req`=0.
- `IRQ_NEST_EN`: ch2 in service, pulse ch0 → `irq_req`, `irq_id`=0. Ack → `in_service`=4'b0101. eoi → 4'b0100 and FSM in SERVICE. eoi → 0.
- Assert `rst` low while in REQ → `irq_req`=0 with no clock edge. All outputs return to reset values.

Source files
------------

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- multi-channel interrupt controller for the mips core.
//
// Synchronises N_CH asynchronous request lines, latches edge-mode events or
// tracks level-mode lines, masks and priority-encodes them (channel 0 is the
// highest priority) and presents a single request plus channel ID to the core
// over an irq_req / irq_ack handshake.  In-service state is kept until the
// handler signals end-of-interrupt (eoi).
//
// Optional feature macro: IRQ_NEST_EN
//   defined   -> nested interrupts: a higher-priority channel may preempt a
//                channel that is in service.
//   undefined -> at most one channel is in service at any time.
//
// Parameters:
//   N_CH        number of channels (1..32)
//   ID_W        width of irq_id (>= clog2(N_CH), minimum 1)
//   SYNC_STAGES synchroniser flops per input (>= 2)
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   irq_in      raw asynchronous interrupt lines
//   mask_we     load mask from mask_wdata (1 = channel enabled)
//   mask_wdata  new mask value
//   mode_we     load mode from mode_wdata (1 = rising edge, 0 = level)
//   mode_wdata  new mode value
//   irq_req     request to the core
//   irq_id      channel being requested, or the last one acknowledged
//   irq_ack     one-cycle pulse: core accepts the request
//   eoi         one-cycle pulse: handler finished
//   pending     pending vector (debug readout)
//   in_service  in-service vector (debug readout)
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int N_CH        = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] irq_in,
  input  logic            mask_we,
  input  logic [N_CH-1:0] mask_wdata,
  input  logic            mode_we,
  input  logic [N_CH-1:0] mode_wdata,
  output logic            irq_req,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ack,
  input  logic            eoi,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] in_service
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t          state_reg, state_next;
  logic            irq_req_reg, irq_req_next;
  logic [ID_W-1:0] irq_id_reg, irq_id_next;
  logic [N_CH-1:0] pending_reg, pending_next;
  logic [N_CH-1:0] is_reg, is_next;
  logic [N_CH-1:0] mask_reg;
  logic [N_CH-1:0] mode_reg;

  logic [N_CH-1:0] synced;
  logic [N_CH-1:0] edge_det;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] ack_clr;
  logic [N_CH-1:0] id_onehot;
  logic [N_CH-1:0] is_low_onehot;
  logic [ID_W-1:0] win_idx;

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser chain plus one history flop for edge detection.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   hist_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_reg <= '0;
          hist_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_in[gi]};
          hist_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      assign synced[gi]   = sync_reg[SYNC_STAGES-1];
      assign edge_det[gi] = sync_reg[SYNC_STAGES-1] & ~hist_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Configuration registers.  They are plain flops, so a write only affects
  // eligibility from the cycle after the write edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_reg <= '0;
      mode_reg <= '1;
    end else begin
      if (mask_we) mask_reg <= mask_wdata;
      if (mode_we) mode_reg <= mode_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending vector.  Edge channels latch until acknowledged, and a new edge in
  // the same cycle as the ack-clear keeps the bit set.  Level channels simply
  // follow the synchronised line, which also covers an edge->level switch.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_next = pending_reg;
    for (int i = 0; i < N_CH; i++) begin
      if (mode_reg[i]) begin
        if (ack_clr[i])  pending_next[i] = 1'b0;
        if (edge_det[i]) pending_next[i] = 1'b1;
      end else begin
        pending_next[i] = synced[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priority encoding.
  // ---------------------------------------------------------------------------
  assign eligible      = pending_reg & mask_reg & ~is_reg;
  assign id_onehot     = N_CH'(1) << irq_id_reg;
  // Isolates the lowest set bit of the in-service vector.
  assign is_low_onehot = is_reg & (~is_reg + N_CH'(1));

  // Descending scan so the lowest eligible index is the one left standing.
  always_comb begin
    win_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = ID_W'(i);
    end
  end

`ifdef IRQ_NEST_EN
  logic [ID_W-1:0] is_low_idx;

  always_comb begin
    is_low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (is_reg[i]) is_low_idx = ID_W'(i);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      irq_req_reg <= 1'b0;
      irq_id_reg  <= '0;
      pending_reg <= '0;
      is_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      irq_req_reg <= irq_req_next;
      irq_id_reg  <= irq_id_next;
      pending_reg <= pending_next;
      is_reg      <= is_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM: next state and registered outputs.  eoi is only honoured in
  // SERVICE, which also makes an ack+eoi pair in REQ process the ack alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    irq_req_next = irq_req_reg;
    irq_id_next  = irq_id_reg;
    is_next      = is_reg;
    ack_clr      = '0;

    unique case (state_reg)
      IDLE: begin
        if (eligible != '0 && is_reg == '0) begin
          irq_id_next  = win_idx;
          irq_req_next = 1'b1;
          state_next   = REQ;
        end
      end

      REQ: begin
        // irq_id stays fixed here; a higher-priority arrival waits its turn.
        if (irq_ack) begin
          irq_req_next = 1'b0;
          is_next      = is_reg | id_onehot;
          ack_clr      = id_onehot & mode_reg;
          state_next   = SERVICE;
        end else if (!mask_reg[irq_id_reg] ||
                     (!mode_reg[irq_id_reg] && !pending_reg[irq_id_reg])) begin
          // Source masked off or level line dropped: withdraw the request.
          irq_req_next = 1'b0;
`ifdef IRQ_NEST_EN
          state_next   = (is_reg != '0) ? SERVICE : IDLE;
`else
          state_next   = IDLE;
`endif
        end
      end

      SERVICE: begin
        if (eoi && is_reg != '0) begin
          is_next = is_reg & ~is_low_onehot;
`ifdef IRQ_NEST_EN
          state_next = ((is_reg & ~is_low_onehot) != '0) ? SERVICE : IDLE;
`else
          state_next = IDLE;
`endif
        end
`ifdef IRQ_NEST_EN
        else if (eligible != '0 && win_idx < is_low_idx) begin
          // Preemption by a strictly higher-priority channel.
          irq_id_next  = win_idx;
          irq_req_next = 1'b1;
          state_next   = REQ;
        end
`endif
      end

      default: begin
        state_next   = IDLE;
        irq_req_next = 1'b0;
      end
    endcase
  end

  assign irq_req    = irq_req_reg;
  assign irq_id     = irq_id_reg;
  assign pending    = pending_reg;
  assign in_service = is_reg;

endmodule
